// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared types and defaults for the countdown timer
//
// Purpose: FSM state encoding and the default counter width.
// Ports:   none (package).
package countdown_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

endpackage

// File: rtl/down_counter_bit.sv
// rtl/down_counter_bit.sv - one bit slice of the rippling down-counter
//
// Purpose: full subtractor (subtrahend fixed at the incoming borrow) feeding
//          a D flip-flop; a parallel load overrides the decrement.
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-low reset (clears q)
//   load       take load_bit instead of the subtractor result
//   load_bit   value to load into this slice
//   borrow_in  borrow from the next lower slice (slice 0: decrement enable)
//   borrow_out borrow passed to the next higher slice
//   q          registered bit value
module down_counter_bit (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic load_bit,
   input  logic borrow_in,
   output logic borrow_out,
   output logic q
);

   logic diff;

   // q - borrow_in: the bit flips when borrowed from, and borrows upward
   // only when it was already 0.
   assign diff       = q ^ borrow_in;
   assign borrow_out = borrow_in & ~q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         q <= 1'b0;
      end else if (load) begin
         q <= load_bit;
      end else begin
         q <= diff;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable, pausable down-counter with done pulse
//
// Purpose: loads a value, counts down one per unpaused cycle while running,
//          and pulses done for one cycle when the count reaches zero.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN - on reaching zero the
//          count reloads from the last loaded value and the run continues,
//          giving a periodic done tick; only load (or reset) stops it.
// Ports:
//   clock       rising-edge clock
//   reset       synchronous, active-low reset
//   load        load load_value (highest priority after reset), go idle
//   load_value  value to load
//   start       begin counting from the current count (idle only)
//   pause       hold everything while running
//   count       current registered count
//   busy        high while running
//   done        one-cycle pulse when the count reaches zero
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             pause,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   state_t           state;
   logic             run_step;
   logic             at_one;
   logic             terminal;
   logic             enable;
   logic             bit_load;
   logic [WIDTH-1:0] bit_value;
   logic [WIDTH:0]   borrow;
   logic [WIDTH-1:0] end_value;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_reg;
   assign end_value = reload_reg;
`else
   assign end_value = '0;
`endif

   assign run_step = (state == ST_RUN) && !pause;
   assign at_one   = (count == WIDTH'(1));

   // The 1 -> 0 (or 1 -> reload) step goes through the parallel load path
   // rather than the borrow chain, so the chain only ever handles count > 1.
   assign terminal = run_step && at_one && !load;
   assign enable   = run_step && !at_one && !load;

   assign bit_load  = load || terminal;
   assign bit_value = load ? load_value : end_value;

   assign borrow[0] = enable;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_bit
         down_counter_bit u_bit (
            .clock      (clock),
            .reset      (reset),
            .load       (bit_load),
            .load_bit   (bit_value[i]),
            .borrow_in  (borrow[i]),
            .borrow_out (borrow[i+1]),
            .q          (count[i])
         );
      end
   endgenerate

   // RUN is only entered with a non-zero count and always leaves (or
   // reloads) at one, so the chain must never borrow out of the top bit.
   underflow_never : assert property (@(posedge clock) disable iff (!reset) !borrow[WIDTH]);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= ST_IDLE;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            state <= ST_IDLE;
         end else if (state == ST_IDLE) begin
            if (start) begin
               if (count == '0) begin
                  done <= 1'b1;
               end else begin
                  state <= ST_RUN;
               end
            end
         end else if (terminal) begin
            done <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            state <= ST_RUN;
`else
            state <= ST_IDLE;
`endif
         end
      end
   end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         reload_reg <= '0;
      end else if (load) begin
         reload_reg <= load_value;
      end
   end
`endif

   assign busy = (state == ST_RUN);

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable, pausable down-counter and timer.
- Loads an N-bit value, counts down by 1 per enabled cycle once started, and pulses done when the count reaches zero.
- Counterpart to the team's ripple up-counter: same bit-slice style (subtractor plus flip-flop per bit, borrow rippling upward).
- Used as a timeout or delay generator next to the counters.

Parameters:
- WIDTH, 4, counter width in bits; must be at least 2.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
- load  input  1  loads load_value into count and into the reload register.
- load_value  input  WIDTH  value to load.
- start  input  1  starts counting from the current count.
- pause  input  1  holds count while RUN; busy stays 1.
- count  output  WIDTH  current count value, registered.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the count reaches zero.

Behaviour:
- Reset (reset==0 at an edge):
  - count=0, reload_reg=0, state=IDLE, busy=0, done=0.
  - Reset overrides every input, including mid-RUN.
- States: IDLE and RUN. busy = (state==RUN), registered.
- done defaults to 0 every cycle unless set by a rule below.
- Priority at each edge: reset > load > start > decrement.
- load, in any state:
  - count<=load_value, reload_reg<=load_value, state<=IDLE, done<=0.
  - load during RUN aborts the run with no done pulse.
  - load and start in the same cycle: start is ignored.
- start in IDLE (no load):
  - count!=0: state<=RUN, count unchanged.
  - count==0: done<=1 for one cycle, state stays IDLE.
- start in RUN is ignored.
- RUN, pause==0:
  - count>1: count<=count-1.
  - count==1: count<=0, done<=1, state<=IDLE.
- RUN, pause==1: all state held.
- Latency: start sampled at edge k with count=N (N>0) gives done high and count==0 immediately after edge k+N, plus one extra edge per paused cycle.
- Count never underflows; no decrement occurs at 0.
- Arithmetic: decrement is subtract-1 with the borrow rippling from bit 0 upward. Slice i decrements when borrow_in_i==1; borrow_in_0 = enable.
- IDLE: count holds; pause has no effect.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - In RUN with count==1 and pause==0: done<=1, count<=reload_reg, state stays RUN (periodic tick with period reload_reg).
  - start with count==0 still gives a single done and stays IDLE.
  - load is the only way to leave RUN, apart from reset.
- Undefined: behaviour as above; the reload register may be optimised away.

Decomposition:
- Package countdown_pkg:
  - state typedef enum logic {ST_IDLE, ST_RUN}.
  - localparam DEFAULT_WIDTH=4.
- One sub-module, down_counter_bit:
  - Contents: full subtractor plus D flip-flop.
  - Ports: clock, reset, load, load_bit, borrow_in, borrow_out, q.
  - Generate-instantiated WIDTH times.
- The top level holds the FSM, reload_reg, done, and the enable (RUN && !pause && !at_one) gating. The count==1 transition is handled by the FSM load path.

Test Plan:
- Reset: reset=0 for 2 cycles with load=1, load_value=4'hF → count=0, busy=0, done=0 after release.
- Basic run: load 5, then start at edge k → busy=1 from k; count 4,3,2,1 at k+1..k+4; count=0, done=1 for exactly one cycle, busy=0 after k+5.
- Pause: load 3, start, assert pause for 2 cycles after the first decrement → count holds at 2 during pause; done arrives at edge k+5 instead of k+3.
- Zero and conflicts:
  - load 0, start → done pulses once, busy never 1.
  - load 7 and start asserted together → count=7, state IDLE, no counting.
- Abort and wrap: load 15, start, load 9 at count=10 → busy=0, count=9, no done pulse. Then start → 9 decrements to 0, covering the full borrow ripple (8→7, 1000→0111).
- COUNTDOWN_AUTO_RELOAD_EN defined: load 3, start → done pulses every 3 cycles with count sequence 2,1,3,2,1,3…; busy stays 1 until load 0 is applied.
